// File: rtl/dense_pkg.sv
// Shared definitions for the dense layer engine.
//   state_t  : 4-bit FSM encodings, IDLE..DONE in sequence (shown on status[3:0])
//   lanes    : number of weight lanes packed in one bus word
//   sat_clip : clamps a wide signed value into the range of an acc_w-bit signed word
package dense_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD_W = 4'd1,
    S_WT_W = 4'd2,
    S_RD_X = 4'd3,
    S_WT_X = 4'd4,
    S_MAC  = 4'd5,
    S_WR   = 4'd6,
    S_NEXT = 4'd7,
    S_DONE = 4'd8
  } state_t;

  function automatic int lanes(input int data_w, input int w_bits);
    return data_w / w_bits;
  endfunction

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int acc_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (acc_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_mac_lanes.sv
// Combinational lane MAC: sums the sign-extended weights of every lane whose
// input bit is set, adds the running accumulator and saturates to ACC_W bits.
// Ports:
//   w_word_i  packed signed weights, lane k at [k*W_BITS +: W_BITS]
//   x_mask_i  one activation bit per lane
//   acc_i     current accumulator
//   acc_o     saturated accumulator + lane sum
module dense_mac_lanes
  import dense_pkg::*;
#(
  parameter int W_BITS = 4,
  parameter int LANES  = 4,
  parameter int ACC_W  = 16
) (
  input  logic [LANES*W_BITS-1:0] w_word_i,
  input  logic [LANES-1:0]        x_mask_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [63:0]       lane_sum;
  logic signed [W_BITS-1:0] term;

  always_comb begin
    lane_sum = '0;
    term     = '0;
    for (int k = 0; k < LANES; k++) begin
      term = w_word_i[k*W_BITS +: W_BITS];
      if (x_mask_i[k]) lane_sum = lane_sum + 64'(term);
    end
    // The wide sum cannot overflow, so clamping once after the add is exact.
    acc_o = ACC_W'(sat_clip(64'(acc_i) + lane_sum, ACC_W));
  end

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine, Avalon-MM master on shared SDRAM.
// For each of N_OUT nodes it streams N_IN/LANES weight words (never rewound)
// and the matching input words, accumulates with saturation, and writes one
// result word to y_base + 2*node. HPS handshake is ready (level) / done.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   ready / done             start request / run complete (held until ready low)
//   x_base, w_base, y_base   byte bases, captured when a run starts
//   address, read_n, write_n, writedata, chipselect, byteenable   Avalon master
//   readdata, waitrequest, readdatavalid                          Avalon slave side
//   status                   {node_cnt[15:0], 12'h0, state[3:0]}
// Build option: define DENSE_RELU_EN to clamp negative results to zero on writeback.
module dense_layer_engine
  import dense_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int W_BITS = 4,
  parameter int N_IN   = 784,
  parameter int N_OUT  = 200,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ready,
  output logic              done,
  input  logic [31:0]       x_base,
  input  logic [31:0]       w_base,
  input  logic [31:0]       y_base,
  output logic [31:0]       address,
  output logic              read_n,
  output logic              write_n,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  output logic              chipselect,
  output logic [1:0]        byteenable,
  output logic [31:0]       status
);

  localparam int LANES  = lanes(DATA_W, W_BITS);
  localparam int WPN    = N_IN / LANES;
  localparam int CNT_W  = $clog2(WPN + 1);
  localparam int NODE_W = $clog2(N_OUT + 1);

  if ((N_IN % LANES) != 0) begin : g_bad_n_in
    $error("dense_layer_engine: N_IN must be a multiple of LANES");
  end
  if (ACC_W < W_BITS + 1) begin : g_bad_acc_w
    $error("dense_layer_engine: ACC_W must be at least W_BITS+1");
  end

  state_t              state_q, state_d;
  logic [31:0]         w_ptr_q, w_ptr_d;
  logic [31:0]         x_ptr_q, x_ptr_d;
  logic [31:0]         y_ptr_q, y_ptr_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [NODE_W-1:0]   node_cnt_q, node_cnt_d;
  logic [31:0]         x_base_q, x_base_d;
  logic [DATA_W-1:0]   w_word_q, w_word_d;
  logic [LANES-1:0]    x_mask_q, x_mask_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_next;

  function automatic logic [DATA_W-1:0] wb_value(input logic signed [ACC_W-1:0] a);
`ifdef DENSE_RELU_EN
    if (a < 0) return '0;
`endif
    return DATA_W'(a);
  endfunction

  dense_mac_lanes #(
    .W_BITS(W_BITS),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_mac (
    .w_word_i(w_word_q),
    .x_mask_i(x_mask_q),
    .acc_i   (acc_q),
    .acc_o   (acc_next)
  );

  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign done       = (state_q == S_DONE);
  assign status     = {16'(node_cnt_q), 12'h000, state_q};

  always_comb begin
    state_d    = state_q;
    w_ptr_d    = w_ptr_q;
    x_ptr_d    = x_ptr_q;
    y_ptr_d    = y_ptr_q;
    word_cnt_d = word_cnt_q;
    node_cnt_d = node_cnt_q;
    x_base_d   = x_base_q;
    w_word_d   = w_word_q;
    x_mask_d   = x_mask_q;
    acc_d      = acc_q;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d    = S_RD_W;
          w_ptr_d    = w_base;
          x_ptr_d    = x_base;
          y_ptr_d    = y_base;
          x_base_d   = x_base;
          word_cnt_d = '0;
          node_cnt_d = '0;
          acc_d      = '0;
        end
      end
      S_RD_W: begin
        read_n  = 1'b0;
        address = w_ptr_q;
        if (!waitrequest) begin
          state_d = S_WT_W;
          w_ptr_d = w_ptr_q + 32'd2;
        end
      end
      S_WT_W: begin
        if (readdatavalid) begin
          w_word_d = readdata;
          state_d  = S_RD_X;
        end
      end
      S_RD_X: begin
        read_n  = 1'b0;
        address = x_ptr_q;
        if (!waitrequest) begin
          state_d = S_WT_X;
          x_ptr_d = x_ptr_q + 32'd2;
        end
      end
      S_WT_X: begin
        if (readdatavalid) begin
          // Only the LSB of each lane carries the binary activation.
          for (int k = 0; k < LANES; k++) x_mask_d[k] = readdata[k*W_BITS];
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_next;
        if (32'(word_cnt_q) < WPN - 1) begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_RD_W;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        write_n   = 1'b0;
        address   = y_ptr_q;
        writedata = wb_value(acc_q);
        if (!waitrequest) begin
          y_ptr_d = y_ptr_q + 32'd2;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // Inputs are reused by every node; weights simply continue.
        x_ptr_d    = x_base_q;
        acc_d      = '0;
        word_cnt_d = '0;
        if (32'(node_cnt_q) < N_OUT - 1) begin
          node_cnt_d = node_cnt_q + 1'b1;
          state_d    = S_RD_W;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      w_ptr_q    <= '0;
      x_ptr_q    <= '0;
      y_ptr_q    <= '0;
      word_cnt_q <= '0;
      node_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      w_ptr_q    <= w_ptr_d;
      x_ptr_q    <= x_ptr_d;
      y_ptr_q    <= y_ptr_d;
      word_cnt_q <= word_cnt_d;
      node_cnt_q <= node_cnt_d;
    end
  end

  // Datapath registers: always (re)initialised when a run starts.
  always_ff @(posedge clk) begin
    x_base_q <= x_base_d;
    w_word_q <= w_word_d;
    x_mask_q <= x_mask_d;
    acc_q    <= acc_d;
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
module tb_dense_layer_engine;

  localparam int DATA_W = 16;
  localparam int W_BITS = 4;
  localparam int N_IN   = 40;
  localparam int N_OUT  = 3;
  localparam int ACC_W  = 8;
  localparam int LANES  = DATA_W / W_BITS;
  localparam int WPN    = N_IN / LANES;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ready = 1'b0;
  logic              done;
  logic [31:0]       x_base = 32'h0;
  logic [31:0]       w_base = 32'h0;
  logic [31:0]       y_base = 32'h0;
  logic [31:0]       address;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata = '0;
  logic              waitrequest = 1'b1;
  logic              readdatavalid = 1'b0;
  logic              chipselect;
  logic [1:0]        byteenable;
  logic [31:0]       status;

  dense_layer_engine #(
    .DATA_W(DATA_W), .W_BITS(W_BITS), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .done(done),
    .x_base(x_base), .w_base(w_base), .y_base(y_base),
    .address(address), .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .chipselect(chipselect), .byteenable(byteenable), .status(status)
  );

  always #5 clk = ~clk;

  // ---------------- SDRAM slave model (updates on negedge) ----------------
  typedef struct packed { logic [31:0] a; logic [15:0] d; } wr_t;
  logic [15:0] mem [int];
  wr_t         wlog [$];
  int          wait_cycles = 0;
  bit          rand_lat = 1'b0;
  int          stall = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_data = '0;
  bit          holding = 1'b0;
  bit          hold_rd = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [15:0] hold_data = '0;
  int          stab_err = 0;

  always @(negedge clk) begin
    readdatavalid = 1'b0;
    readdata      = 16'($urandom);
    waitrequest   = 1'b1;
    if (!reset_n) begin
      pend = 1'b0; stall = 0; holding = 1'b0;
    end else if (pend) begin
      if (pend_cnt == 0) begin
        readdatavalid = 1'b1;
        readdata      = pend_data;
        pend          = 1'b0;
      end else pend_cnt--;
    end else if (!read_n || !write_n) begin
      if (holding && (address !== hold_addr || hold_rd !== !read_n ||
                      (!write_n && writedata !== hold_data))) stab_err++;
      holding = 1'b1; hold_rd = !read_n; hold_addr = address; hold_data = writedata;
      if (stall < wait_cycles) stall++;
      else begin
        waitrequest = 1'b0; stall = 0; holding = 1'b0;
        if (!read_n) begin
          pend      = 1'b1;
          pend_data = mem.exists(int'(address >> 1)) ? mem[int'(address >> 1)] : 16'h0;
          pend_cnt  = rand_lat ? int'($urandom_range(0, 2)) : 0;
        end else wlog.push_back({address, writedata});
      end
    end else begin
      if (holding) stab_err++;
      holding = 1'b0;
      // stray valid pulses outside a pending read must be ignored
      if ($urandom_range(0, 3) == 0) readdatavalid = 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: per node, walk the weight words and input words, add each
  // selected signed nibble, clamp after every word.
  function automatic logic [15:0] model_node(input logic [31:0] xb, input logic [31:0] wb, input int n);
    int acc = 0;
    for (int j = 0; j < WPN; j++) begin
      logic [15:0] xw, ww;
      xw = mem[int'(xb >> 1) + j];
      ww = mem[int'(wb >> 1) + n * WPN + j];
      for (int k = 0; k < LANES; k++) begin
        if (xw[k*W_BITS]) begin
          int t = int'(ww[k*W_BITS +: W_BITS]);
          if (t >= (1 << (W_BITS - 1))) t -= (1 << W_BITS);
          acc += t;
        end
      end
      if (acc > ACC_MAX) acc = ACC_MAX;
      if (acc < ACC_MIN) acc = ACC_MIN;
    end
`ifdef DENSE_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 16'(acc);
  endfunction

  task automatic fill(input logic [31:0] xb, input logic [31:0] wb,
                      input logic [15:0] xpat, input logic [15:0] wpat, input bit rnd);
    for (int j = 0; j < WPN; j++) mem[int'(xb >> 1) + j] = rnd ? 16'($urandom) : xpat;
    for (int j = 0; j < N_OUT * WPN; j++) mem[int'(wb >> 1) + j] = rnd ? 16'($urandom) : wpat;
  endtask

  task automatic run_layer(input string tag, input logic [31:0] xb, input logic [31:0] wb,
                           input logic [31:0] yb, input int waits, input bit rl,
                           input int exp_cycles);
    logic [15:0] expy [N_OUT];
    int cycles, wbase, sbase;
    for (int n = 0; n < N_OUT; n++) expy[n] = model_node(xb, wb, n);
    wait_cycles = waits; rand_lat = rl;
    wbase = wlog.size(); sbase = stab_err;
    x_base = xb; w_base = wb; y_base = yb;
    ready = 1'b1;
    cycles = 0;
    while (done !== 1'b1 && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 2) begin
        x_base = $urandom; w_base = $urandom; y_base = $urandom;
      end
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    if (exp_cycles > 0) chk({tag, "_cycles"}, cycles, exp_cycles);
    chk({tag, "_nwrites"}, wlog.size() - wbase, N_OUT);
    for (int n = 0; n < N_OUT; n++) begin
      if (wbase + n < wlog.size()) begin
        chk($sformatf("%s_addr%0d", tag, n), wlog[wbase+n].a, yb + 32'(2 * n));
        chk($sformatf("%s_data%0d", tag, n), {16'd0, wlog[wbase+n].d}, {16'd0, expy[n]});
      end
    end
    chk({tag, "_bus_stable"}, stab_err - sbase, 0);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_done_held"}, {31'd0, done}, 32'd1);
    chk({tag, "_status_done"}, status, {16'(N_OUT - 1), 12'h000, 4'd8});
    ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    chk({tag, "_state_idle"}, {28'd0, status[3:0]}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] e;
    int guard;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_n", {31'd0, read_n}, 32'd1);
    chk("rst_write_n", {31'd0, write_n}, 32'd1);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", {16'd0, writedata}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_status", status, 32'd0);
    chk("tie_cs_be", {29'd0, chipselect, byteenable}, 32'd7);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // all ones: +1 per lane, 40 active lanes
    fill(32'h100, 32'h1000, 16'h1111, 16'h1111, 1'b0);
    run_layer("pos", 32'h100, 32'h1000, 32'h4000, 0, 1'b0, 1 + N_OUT * (5 * WPN + 2));
    // -1 per lane, three stall cycles on every request
    fill(32'h100, 32'h1000, 16'h1111, 16'hFFFF, 1'b0);
    run_layer("neg_ws3", 32'h100, 32'h1000, 32'h4000, 3, 1'b0, 1 + N_OUT * (11 * WPN + 5));
    // saturation high and low
    fill(32'h100, 32'h1000, 16'h1111, 16'h7777, 1'b0);
    run_layer("sat_hi", 32'h100, 32'h1000, 32'h4000, 0, 1'b1, 0);
    fill(32'h100, 32'h1000, 16'h1111, 16'h8888, 1'b0);
    run_layer("sat_lo", 32'h100, 32'h1000, 32'h4100, 1, 1'b1, 0);
    // no active inputs
    fill(32'h100, 32'h1000, 16'h0000, 16'h7777, 1'b0);
    run_layer("x_zero", 32'h100, 32'h1000, 32'h4000, 0, 1'b0, 0);
    // random data
    for (int r = 0; r < 3; r++) begin
      fill(32'h200, 32'h2000, 16'h0, 16'h0, 1'b1);
      run_layer($sformatf("rnd%0d", r), 32'h200, 32'h2000, 32'h6000,
                int'($urandom_range(0, 2)), 1'b1, 0);
    end

    // abort during the input wait of node 1, then restart
    fill(32'h200, 32'h2000, 16'h0, 16'h0, 1'b1);
    e = model_node(32'h200, 32'h2000, 0);
    guard = wlog.size();
    wait_cycles = 1; rand_lat = 1'b1;
    x_base = 32'h200; w_base = 32'h2000; y_base = 32'h6000;
    ready = 1'b1;
    begin
      int c = 0;
      while (!(status[3:0] == 4'd4 && status[31:16] == 16'd1) && c < 2000) begin
        @(posedge clk); #1; c++;
      end
      chk("abort_reached", {31'd0, c < 2000}, 32'd1);
    end
    reset_n = 1'b0;
    ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_read_n", {31'd0, read_n}, 32'd1);
    chk("abort_write_n", {31'd0, write_n}, 32'd1);
    chk("abort_state", {28'd0, status[3:0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_nwrites", wlog.size() - guard, 1);
    if (wlog.size() > guard) chk("abort_node0", {16'd0, wlog[guard].d}, {16'd0, e});
    fill(32'h200, 32'h2000, 16'h0, 16'h0, 1'b1);
    run_layer("restart", 32'h200, 32'h2000, 32'h6000, 0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
